spi_frame_scaler: RTL and testbench

Parametrised successor to the low-res SPI capture buffer. It captures a frame of PIX_W-bit pixels from the SPI byte stream into a ping-pong (double-buffered) frame store. On each Next_Line request it replays one stored row to the video pipeline, replicating every pixel and row SCALE times. It sits between the SPI receiver and the VGA line generator, and adds frame-complete and overrun flags.

---
 rtl/spi_frame_scaler_if.sv | 34 +++
 rtl/spi_frame_scaler.sv | 195 +++++++++++++++++++
 tb/tb_spi_frame_scaler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_scaler_if.sv
// Signal bundle between the SPI receiver, the VGA line generator and spi_frame_scaler.
// The test_mode input is present only when TEST_PATTERN_EN is defined.
interface spi_frame_scaler_if #(
   parameter int PIX_W     = 8,
   parameter int ROW_SEL_W = 8
);
   logic [PIX_W:0]         Data;
   logic                   clk_SPI;
   logic                   Next_Line;
   logic [ROW_SEL_W-1:0]   Row_Select;
   logic [PIX_W-1:0]       Data_Frame;
   logic                   Data_Valid;
   logic                   Frame_Ready;
   logic                   Overrun;
`ifdef TEST_PATTERN_EN
   logic                   test_mode;
`endif

   modport master (
      output Data, clk_SPI, Next_Line, Row_Select,
`ifdef TEST_PATTERN_EN
      output test_mode,
`endif
      input  Data_Frame, Data_Valid, Frame_Ready, Overrun
   );

   modport slave (
      input  Data, clk_SPI, Next_Line, Row_Select,
`ifdef TEST_PATTERN_EN
      input  test_mode,
`endif
      output Data_Frame, Data_Valid, Frame_Ready, Overrun
   );
endinterface

// File: rtl/spi_frame_scaler.sv
// Captures SPI pixel frames into a ping-pong store and replays rows scaled by SCALE.
// Define TEST_PATTERN_EN to add the test_mode input that outputs (col ^ row) pixels.
module spi_frame_scaler #(
   parameter int PIX_W     = 8,
   parameter int COLS      = 160,
   parameter int ROWS      = 120,
   parameter int SCALE     = 2,
   parameter int ROW_SEL_W = 8
) (
   input  logic              CLK,
   input  logic              reset,
   spi_frame_scaler_if.slave bus
);
   localparam int DEPTH  = ROWS * COLS;
   localparam int ADDR_W = $clog2(2 * DEPTH);
   localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int REP_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, LINE} rdState_t;

   logic [1:0]           r_spiSync;
   logic                 r_spiPrev;
   logic [PIX_W:0]       r_dataS1;
   logic [PIX_W:0]       r_dataS2;
   logic [ROW_W-1:0]     r_wrRow;
   logic [COL_W-1:0]     r_wrCol;
   logic                 r_complete;
   logic                 r_swapPending;
   logic                 r_frontBank;
   logic                 r_frameReady;
   logic                 r_overrun;
   rdState_t             r_state;
   logic [ROW_SEL_W-1:0] r_srcRow;
   logic [COL_W-1:0]     r_rdCol;
   logic [REP_W-1:0]     r_rep;
   logic [PIX_W-1:0]     r_mem [2*DEPTH];
   logic [PIX_W-1:0]     r_rdData;

   logic                 w_spiRise;
   logic                 w_sof;
   logic [PIX_W-1:0]     w_pix;
   logic                 w_drop;
   logic                 w_wrEn;
   logic [ROW_W-1:0]     w_wrRow;
   logic [COL_W-1:0]     w_wrCol;
   logic                 w_wrLast;
   logic                 w_swap;
   logic                 w_wrBank;
   logic [ADDR_W-1:0]    w_wrAddr;
   logic [ADDR_W-1:0]    w_rdAddr;
   rdState_t             w_stateNext;
   logic [ROW_SEL_W-1:0] w_srcRowNext;
   logic [COL_W-1:0]     w_rdColNext;
   logic [REP_W-1:0]     w_repNext;
   logic                 w_rowValid;
   logic                 w_rowValidNext;
   logic [PIX_W-1:0]     w_dataFrame;

   // Data travels through the same two-flop depth as the strobe, so it is aligned with the detected edge
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_spiSync <= '0;
         r_spiPrev <= 1'b0;
         r_dataS1  <= '0;
         r_dataS2  <= '0;
      end else begin
         r_spiSync <= {r_spiSync[0], bus.clk_SPI};
         r_spiPrev <= r_spiSync[1];
         r_dataS1  <= bus.Data;
         r_dataS2  <= r_dataS1;
      end
   end

   assign w_spiRise = r_spiSync[1] & ~r_spiPrev;
   assign w_sof     = r_dataS2[PIX_W];
   assign w_pix     = r_dataS2[PIX_W-1:0];
   assign w_drop    = w_spiRise & ~w_sof & r_complete;
   assign w_wrEn    = w_spiRise & ~w_drop;
   assign w_wrRow   = w_sof ? '0 : r_wrRow;
   assign w_wrCol   = w_sof ? '0 : r_wrCol;
   assign w_wrLast  = w_wrEn && (w_wrRow == ROW_W'(ROWS - 1)) && (w_wrCol == COL_W'(COLS - 1));
   assign w_swap    = (r_state == IDLE) & (r_swapPending | w_wrLast);
   // A restart word landing on an older pending swap must go to the bank that becomes back after it
   assign w_wrBank  = (w_swap & r_swapPending) ? r_frontBank : ~r_frontBank;
   assign w_wrAddr  = ADDR_W'(int'(w_wrBank) * DEPTH + int'(w_wrRow) * COLS + int'(w_wrCol));

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_wrRow       <= '0;
         r_wrCol       <= '0;
         r_complete    <= 1'b0;
         r_swapPending <= 1'b0;
         r_frontBank   <= 1'b0;
         r_frameReady  <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         if (w_wrEn) begin
            if (w_wrCol == COL_W'(COLS - 1)) begin
               r_wrCol <= '0;
               r_wrRow <= (w_wrRow == ROW_W'(ROWS - 1)) ? '0 : w_wrRow + 1'b1;
            end else begin
               r_wrCol <= w_wrCol + 1'b1;
               r_wrRow <= w_wrRow;
            end
         end
         if (w_swap) begin
            r_frontBank   <= ~r_frontBank;
            r_swapPending <= 1'b0;
            r_complete    <= 1'b0;
            r_frameReady  <= 1'b1;
         end else if (w_wrLast) begin
            r_complete    <= 1'b1;
            r_swapPending <= 1'b1;
         end else if (w_wrEn & w_sof) begin
            r_complete    <= 1'b0;
         end
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_srcRowNext = r_srcRow;
      w_rdColNext  = r_rdCol;
      w_repNext    = r_rep;
      if (bus.Next_Line) begin
         w_stateNext  = FETCH;
         w_srcRowNext = bus.Row_Select / ROW_SEL_W'(SCALE);
         w_rdColNext  = '0;
         w_repNext    = '0;
      end else begin
         case (r_state)
            FETCH: w_stateNext = LINE;
            LINE: begin
               if (r_rep == REP_W'(SCALE - 1)) begin
                  w_repNext = '0;
                  if (r_rdCol == COL_W'(COLS - 1)) begin
                     w_stateNext = IDLE;
                     w_rdColNext = '0;
                  end else begin
                     w_rdColNext = r_rdCol + 1'b1;
                  end
               end else begin
                  w_repNext = r_rep + 1'b1;
               end
            end
            default: w_stateNext = r_state;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_srcRow <= '0;
         r_rdCol  <= '0;
         r_rep    <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_srcRow <= w_srcRowNext;
         r_rdCol  <= w_rdColNext;
         r_rep    <= w_repNext;
      end
   end

   // The read runs one cycle ahead on the next (row, col), so LINE always sees its own pixel
   assign w_rowValidNext = int'(w_srcRowNext) < ROWS;
   assign w_rowValid     = int'(r_srcRow) < ROWS;
   assign w_rdAddr = ADDR_W'(int'(r_frontBank) * DEPTH
                     + (w_rowValidNext ? int'(w_srcRowNext) : 0) * COLS
                     + int'(w_rdColNext));

   always_ff @(posedge CLK) begin
      if (w_wrEn) r_mem[w_wrAddr] <= w_pix;
      r_rdData <= r_mem[w_rdAddr];
   end

   always_comb begin
      w_dataFrame = '0;
      if (r_state == LINE) begin
`ifdef TEST_PATTERN_EN
         if (bus.test_mode) w_dataFrame = PIX_W'(r_rdCol) ^ PIX_W'(r_srcRow);
         else if (r_frameReady && w_rowValid) w_dataFrame = r_rdData;
`else
         if (r_frameReady && w_rowValid) w_dataFrame = r_rdData;
`endif
      end
   end

   assign bus.Data_Frame  = w_dataFrame;
   assign bus.Data_Valid  = (r_state == LINE);
   assign bus.Frame_Ready = r_frameReady;
   assign bus.Overrun     = r_overrun;
endmodule

// File: tb/tb_spi_frame_scaler.sv
// Self-checking bench for spi_frame_scaler (COLS=4, ROWS=2, SCALE=2) against a frame-level model.
module tb_spi_frame_scaler;
   localparam int PIX_W     = 8;
   localparam int COLS      = 4;
   localparam int ROWS      = 2;
   localparam int SCALE     = 2;
   localparam int ROW_SEL_W = 8;
   localparam int DEPTH     = ROWS * COLS;

   logic CLK = 1'b0;
   logic rst_n;
   int   testsRun = 0;
   int   testsFailed = 0;

   spi_frame_scaler_if #(.PIX_W(PIX_W), .ROW_SEL_W(ROW_SEL_W)) bus ();

   spi_frame_scaler #(
      .PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .SCALE(SCALE), .ROW_SEL_W(ROW_SEL_W)
   ) dut (
      .CLK   (CLK),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Frame-level model: two banks of pixels, a linear write position, and the swap/ready flags
   int modelMem [2][DEPTH];
   int modelFront;
   int modelWrPos;
   bit modelComplete;
   bit modelPending;
   bit modelReady;
   int expOverruns;
   int ovCount = 0;
   bit keepBusy = 0;

   logic       capV [0:31];
   logic [7:0] capD [0:31];
   logic       capR [0:31];

   always @(negedge CLK) if (bus.Overrun === 1'b1) ovCount++;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      modelFront = 0; modelWrPos = 0; modelComplete = 0; modelPending = 0; modelReady = 0;
   endtask

   task automatic modelWrite(input bit sof, input int pix);
      if (sof) begin
         modelComplete = 0;
         modelWrPos = 0;
      end else if (modelComplete) begin
         expOverruns++;
         return;
      end
      modelMem[1 - modelFront][modelWrPos] = pix;
      modelWrPos++;
      if (modelWrPos == DEPTH) begin
         modelWrPos = 0; modelComplete = 1; modelPending = 1;
      end
   endtask

   task automatic modelIdle();
      if (modelPending) begin
         modelFront = 1 - modelFront; modelPending = 0; modelComplete = 0; modelReady = 1;
      end
   endtask

   function automatic int expPix(int rowSel, int col);
      int src = rowSel / SCALE;
      if (modelReady && src < ROWS) return modelMem[modelFront][src * COLS + col];
      return 0;
   endfunction

   task automatic sendWord(input bit sof, input logic [7:0] pix);
      @(negedge CLK);
      bus.Data = {sof, pix};
      @(negedge CLK);
      bus.clk_SPI = 1'b1;
      repeat (4) @(negedge CLK);
      bus.clk_SPI = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic putWord(input bit sof, input logic [7:0] pix);
      sendWord(sof, pix);
      modelWrite(sof, int'(pix));
      if (!keepBusy) modelIdle();
   endtask

   task automatic captureLine(input int rowSel, input int n, input int restartAt, input int rowSel2);
      @(negedge CLK);
      bus.Next_Line = 1'b1;
      bus.Row_Select = 8'(rowSel);
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         capV[k] = bus.Data_Valid; capD[k] = bus.Data_Frame; capR[k] = bus.Frame_Ready;
         bus.Next_Line = (k == restartAt);
         if (k == restartAt) bus.Row_Select = 8'(rowSel2);
      end
      bus.Next_Line = 1'b0;
   endtask

   task automatic test_reset();
      logic expV; logic [7:0] expD;
      rst_n = 1'b0;
      repeat (3) @(negedge CLK);
      testsRun++; if (bus.Data_Valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_valid: got %b want 0", bus.Data_Valid); end
      testsRun++; if (bus.Data_Frame !== 8'h00) begin testsFailed++; $display("[TB] FAIL rst_frame: got %h want 00", bus.Data_Frame); end
      testsRun++; if (bus.Frame_Ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_ready: got %b want 0", bus.Frame_Ready); end
      testsRun++; if (bus.Overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_overrun: got %b want 0", bus.Overrun); end
      rst_n = 1'b1;
      modelReset();
      repeat (3) @(negedge CLK);
      captureLine(0, 10, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         expV = (k >= 2 && k <= 9);
         testsRun++; if (capV[k] !== expV) begin testsFailed++; $display("[TB] FAIL reset_line valid[%0d]: got %b want %b", k, capV[k], expV); end
         testsRun++; if (capD[k] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_line data[%0d]: got %h want 00", k, capD[k]); end
      end
      testsRun++; if (capR[5] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_line ready: got %b want 0", capR[5]); end
   endtask

   task automatic test_capture();
      logic expV; logic [7:0] expD;
      putWord(1'b1, 8'h10);
      for (int i = 1; i < DEPTH; i++) putWord(1'b0, 8'(8'h10 + i));
      testsRun++; if (bus.Frame_Ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL capture_ready: got %b want 1", bus.Frame_Ready); end
      for (int r = 0; r < 4; r += 2) begin
         captureLine(r + 2 - 2 * (r / 2) * 2 + r, 10, 0, 0);
         for (int k = 1; k <= 10; k++) begin
            expV = (k >= 2 && k <= 9);
            expD = expV ? 8'(expPix(r + 2 - 2 * (r / 2) * 2 + r, (k - 2) / SCALE)) : 8'h00;
            testsRun++; if (capV[k] !== expV) begin testsFailed++; $display("[TB] FAIL capture_line%0d valid[%0d]: got %b want %b", r, k, capV[k], expV); end
            testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL capture_line%0d data[%0d]: got %h want %h", r, k, capD[k], expD); end
         end
      end
      // Row_Select=2 maps to source row 1, which must hold 0x14..0x17 doubled
      testsRun++; if (expPix(2, 0) != 'h14 || expPix(2, 3) != 'h17) begin testsFailed++; $display("[TB] FAIL capture_model row1: got %h..%h want 14..17", expPix(2, 0), expPix(2, 3)); end
   endtask

   task automatic test_overrun();
      logic expV; logic [7:0] expD;
      int ovStart = ovCount;
      int expStart = expOverruns;
      keepBusy = 1;
      fork
         begin
            putWord(1'b1, 8'h10);
            for (int i = 1; i < DEPTH; i++) putWord(1'b0, 8'(8'h10 + i));
            putWord(1'b0, 8'h99);
            repeat (4) @(negedge CLK);
            keepBusy = 0;
         end
         begin
            while (keepBusy) begin
               @(negedge CLK); bus.Next_Line = 1'b1; bus.Row_Select = 8'd0;
               @(negedge CLK); bus.Next_Line = 1'b0;
               repeat (3) @(negedge CLK);
            end
         end
      join
      repeat (12) @(negedge CLK);
      modelIdle();
      testsRun++; if (ovCount - ovStart !== expOverruns - expStart) begin testsFailed++; $display("[TB] FAIL overrun_count: got %0d want %0d", ovCount - ovStart, expOverruns - expStart); end
      testsRun++; if (ovCount - ovStart !== 1) begin testsFailed++; $display("[TB] FAIL overrun_once: got %0d want 1", ovCount - ovStart); end
      for (int r = 0; r <= 2; r += 2) begin
         captureLine(r, 10, 0, 0);
         for (int k = 2; k <= 9; k++) begin
            expD = 8'(expPix(r, (k - 2) / SCALE));
            testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL overrun_line%0d data[%0d]: got %h want %h", r, k, capD[k], expD); end
         end
      end
   endtask

   task automatic test_swap_during_line();
      logic expV; logic [7:0] expD; logic [7:0] newPix [DEPTH];
      int row = $urandom_range(0, 3);
      for (int i = 0; i < DEPTH; i++) newPix[i] = 8'(modelMem[modelFront][i]) ^ 8'($urandom_range(1, 255));
      putWord(1'b1, newPix[0]);
      for (int i = 1; i < DEPTH - 1; i++) putWord(1'b0, newPix[i]);
      fork
         captureLine(row, 10, 0, 0);
         sendWord(1'b0, newPix[DEPTH - 1]);
      join
      for (int k = 1; k <= 10; k++) begin
         expV = (k >= 2 && k <= 9);
         expD = expV ? 8'(expPix(row, (k - 2) / SCALE)) : 8'h00;
         testsRun++; if (capV[k] !== expV) begin testsFailed++; $display("[TB] FAIL swap_old valid[%0d]: got %b want %b", k, capV[k], expV); end
         testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL swap_old data[%0d]: got %h want %h", k, capD[k], expD); end
      end
      modelWrite(1'b0, int'(newPix[DEPTH - 1]));
      modelIdle();
      captureLine(row, 10, 0, 0);
      for (int k = 2; k <= 9; k++) begin
         expD = 8'(expPix(row, (k - 2) / SCALE));
         testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL swap_new data[%0d]: got %h want %h", k, capD[k], expD); end
      end
   endtask

   task automatic test_restart();
      logic expV; logic [7:0] expD;
      captureLine(3, 15, 4, 1);
      for (int k = 1; k <= 15; k++) begin
         if (k == 2 || k == 3) begin expV = 1'b1; expD = 8'(expPix(3, 0)); end
         else if (k == 4) begin expV = 1'b1; expD = 8'(expPix(3, 1)); end
         else if (k >= 6 && k <= 13) begin expV = 1'b1; expD = 8'(expPix(1, (k - 6) / SCALE)); end
         else begin expV = 1'b0; expD = 8'h00; end
         testsRun++; if (capV[k] !== expV) begin testsFailed++; $display("[TB] FAIL restart valid[%0d]: got %b want %b", k, capV[k], expV); end
         testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL restart data[%0d]: got %h want %h", k, capD[k], expD); end
      end
   endtask

   task automatic test_reset_midway();
      logic expV; logic [7:0] expD;
      putWord(1'b1, 8'($urandom));
      for (int i = 0; i < 3; i++) putWord(1'b0, 8'($urandom));
      @(negedge CLK); bus.Next_Line = 1'b1; bus.Row_Select = 8'd2;
      @(negedge CLK); bus.Next_Line = 1'b0;
      repeat (3) @(negedge CLK);
      testsRun++; if (bus.Data_Valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_pre valid: got %b want 1", bus.Data_Valid); end
      rst_n = 1'b0;
      #1;
      testsRun++; if (bus.Data_Valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_valid: got %b want 0", bus.Data_Valid); end
      testsRun++; if (bus.Data_Frame !== 8'h00) begin testsFailed++; $display("[TB] FAIL midreset_frame: got %h want 00", bus.Data_Frame); end
      testsRun++; if (bus.Frame_Ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_ready: got %b want 0", bus.Frame_Ready); end
      testsRun++; if (bus.Overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_overrun: got %b want 0", bus.Overrun); end
      modelReset();
      @(negedge CLK); rst_n = 1'b1;
      repeat (2) @(negedge CLK);
      putWord(1'b1, 8'($urandom));
      for (int i = 1; i < DEPTH; i++) putWord(1'b0, 8'($urandom));
      for (int r = 0; r < 4; r++) begin
         captureLine(r, 10, 0, 0);
         for (int k = 1; k <= 10; k++) begin
            expV = (k >= 2 && k <= 9);
            expD = expV ? 8'(expPix(r, (k - 2) / SCALE)) : 8'h00;
            testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL postreset_row%0d data[%0d]: got %h want %h", r, k, capD[k], expD); end
         end
      end
   endtask

   task automatic test_random();
      logic expV; logic [7:0] expD;
      int row;
      for (int iter = 0; iter < 4; iter++) begin
         if ($urandom_range(0, 1) == 1) begin
            putWord(1'b1, 8'($urandom));
            for (int i = 0; i < $urandom_range(0, DEPTH - 2); i++) putWord(1'b0, 8'($urandom));
         end
         putWord(1'b1, 8'($urandom));
         for (int i = 1; i < DEPTH; i++) putWord(1'b0, 8'($urandom));
         for (int n = 0; n < 3; n++) begin
            row = $urandom_range(0, 7);
            captureLine(row, 10, 0, 0);
            for (int k = 1; k <= 10; k++) begin
               expV = (k >= 2 && k <= 9);
               expD = expV ? 8'(expPix(row, (k - 2) / SCALE)) : 8'h00;
               testsRun++; if (capV[k] !== expV) begin testsFailed++; $display("[TB] FAIL random%0d_row%0d valid[%0d]: got %b want %b", iter, row, k, capV[k], expV); end
               testsRun++; if (capD[k] !== expD) begin testsFailed++; $display("[TB] FAIL random%0d_row%0d data[%0d]: got %h want %h", iter, row, k, capD[k], expD); end
            end
         end
      end
   endtask

   initial begin
      bus.Data = '0;
      bus.clk_SPI = 1'b0;
      bus.Next_Line = 1'b0;
      bus.Row_Select = '0;
`ifdef TEST_PATTERN_EN
      bus.test_mode = 1'b0;
`endif
      expOverruns = 0;
      for (int b = 0; b < 2; b++) for (int i = 0; i < DEPTH; i++) modelMem[b][i] = 0;
      modelReset();
      test_reset();
      test_capture();
      test_overrun();
      test_swap_during_line();
      test_restart();
      test_reset_midway();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
